stack_reverse_ctrl: RTL

//  Initiator for the 4-bit x 8 push/pop stack. The block drives the stack's enable, push_pop and data_in

---
 rtl/stack_reverse_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/stack_reverse_ctrl.sv
// rtl/stack_reverse_ctrl.sv - stream reversal stage driving a push/pop LIFO stack
module stack_reverse_ctrl #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              stk_enable,
    output logic              stk_push_pop,
    output logic [DATA_W-1:0] stk_data_in,
    input  logic              stk_full,
    input  logic              stk_empty,
    input  logic [DATA_W-1:0] stk_data_out,
    output logic              seg_done,
    output logic              err
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             last_seen;
    logic             ret_chk;   // first FILL cycle after a drain: stack must read empty
    logic             accept;
    logic             pop;
    logic             err_set;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshakes, stack strobes and protocol-check conditions
    always_comb begin
        state_next   = state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_last     = 1'b0;
        accept       = 1'b0;
        pop          = 1'b0;
        seg_done     = 1'b0;
        stk_enable   = 1'b0;
        stk_push_pop = 1'b0;
        stk_data_in  = '0;
        err_set      = 1'b0;
        case (state)
            FILL: begin
                // gated by reset so every output reads 0 while reset is held
                in_ready = reset && (cnt != CNT_FULL);
                accept   = in_valid && in_ready;
                if (accept) begin
                    stk_enable   = 1'b1;
                    stk_push_pop = 1'b1;
                    stk_data_in  = in_data;
                    // close the segment on in_last or when this push fills the stack
                    if (in_last || (cnt == CNT_FULL - CNT_ONE)) begin
                        state_next = DRAIN;
                    end
                end
                err_set = (stk_full && (cnt < CNT_FULL)) || (ret_chk && !stk_empty);
            end
            DRAIN: begin
                out_valid = (cnt != '0);
                out_data  = stk_data_out;
                out_last  = last_seen && (cnt == CNT_ONE);
                pop       = out_valid && out_ready;
                if (pop) begin
                    stk_enable = 1'b1;
                    if (cnt == CNT_ONE) begin
                        seg_done   = 1'b1;
                        state_next = FILL;
                    end
                end
                err_set = stk_empty && (cnt != '0);
            end
            default: state_next = FILL;
        endcase
    end

    // Occupancy counter, frame-end tracking and sticky error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            last_seen <= 1'b0;
            ret_chk   <= 1'b0;
            err       <= 1'b0;
        end else begin
            ret_chk <= seg_done;
            if (err_set) begin
                err <= 1'b1;
            end
            if (accept) begin
                cnt <= cnt + CNT_ONE;
                if (in_last) begin
                    last_seen <= 1'b1;
                end
            end else if (pop) begin
                cnt <= cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    last_seen <= 1'b0;
                end
            end
        end
    end

endmodule
